// File: rtl/pulse_stretch_queue_pkg.sv
// Shared types and width helpers for the pulse stretch queue.
// The PULSE_MERGE_EN build option is handled in the queue and top files.
package pulse_sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bits needed to hold any value 0..n (never narrower than one bit)
  function automatic int width_for(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_queue_fifo.sv
// DEPTH x WIDTH register FIFO with occupancy count and registered full/empty.
// With PULSE_MERGE_EN defined, a merge input ORs din into the newest entry.
module pulse_queue
  import pulse_sync_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
`ifdef PULSE_MERGE_EN
  input  logic                          merge,
`endif
  input  logic [WIDTH-1:0]              din,
  output logic [WIDTH-1:0]              dout,
  output logic [width_for(DEPTH)-1:0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = width_for(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             full_r;
  logic             empty_r;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic [LW-1:0]    level_nxt_s;

  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);

  // Next occupancy; a simultaneous push and pop leaves it unchanged
  always_comb begin
    level_nxt_s = level_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LW'(1);
      2'b01:   level_nxt_s = level_r - LW'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Storage, pointers and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
`ifdef PULSE_MERGE_EN
      else if (merge && full_r) begin
        mem_r[wr_ptr_r - AW'(1)] <= mem_r[wr_ptr_r - AW'(1)] | din;
      end
`endif
      if (pop_ok_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LW'(DEPTH));
      empty_r <= (level_nxt_s == {LW{1'b0}});
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign level = level_r;
  assign full  = full_r;
  assign empty = empty_r;

endmodule

// File: rtl/pulse_stretch_queue.sv
// Queues single-cycle event vectors and replays each as a HOLD-cycle pulse plus GAP idle cycles.
// Define PULSE_MERGE_EN to OR-merge events into the newest entry when full instead of dropping them.
module pulse_stretch_queue
  import pulse_sync_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int HOLD  = 2,
  parameter int GAP   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              sig_in,
  output logic [WIDTH-1:0]              sig_out,
  output logic                          busy,
  output logic                          overflow,
  output logic [width_for(DEPTH)-1:0]   level
);

  localparam int CW      = width_for((HOLD > GAP) ? HOLD : GAP);
  localparam int HOLD_M1 = HOLD - 1;
  localparam int GAP_M1  = (GAP > 0) ? GAP - 1 : 0;

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sig_out_r;
  logic [WIDTH-1:0] head_s;
  logic             full_s;
  logic             empty_s;
  logic             has_event_s;
  logic             pop_s;
  logic             push_s;
  logic             full_hit_s;

  assign has_event_s = |sig_in;
  assign pop_s       = (state_r == ST_IDLE) && !empty_s;
  assign push_s      = has_event_s && (!full_s || pop_s);
  assign full_hit_s  = has_event_s && full_s && !pop_s;

  pulse_queue #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
`ifdef PULSE_MERGE_EN
    .merge (full_hit_s),
`endif
    .din   (sig_in),
    .dout  (head_s),
    .level (level),
    .full  (full_s),
    .empty (empty_s)
  );

  // Replay FSM: the popped head is held, then forced low for the gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CW{1'b0}};
      sig_out_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r   <= ST_HOLD;
            cnt_r     <= CW'(HOLD_M1);
            sig_out_r <= head_s;
          end
        end
        ST_HOLD: begin
          if (cnt_r == {CW{1'b0}}) begin
            sig_out_r <= {WIDTH{1'b0}};
            if (GAP == 0) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_GAP;
              cnt_r   <= CW'(GAP_M1);
            end
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        ST_GAP: begin
          if (cnt_r == {CW{1'b0}}) state_r <= ST_IDLE;
          else                     cnt_r   <= cnt_r - CW'(1);
        end
        default: begin
          state_r   <= ST_IDLE;
          cnt_r     <= {CW{1'b0}};
          sig_out_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

`ifdef PULSE_MERGE_EN
  assign overflow = 1'b0;
`else
  logic overflow_r;

  // Flag a dropped event for exactly the following cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_r <= 1'b0;
    else      overflow_r <= full_hit_s;
  end

  assign overflow = overflow_r;
`endif

  assign sig_out = sig_out_r;
  assign busy    = full_s;

endmodule
